led_pattern_scheduler: RTL and testbench

//  Shares the single board LED between NUM_REQ requesters (RNG status, error flags, etc).

---
 rtl/led_pattern_scheduler_pkg.sv | 18 +
 rtl/led_pattern_scheduler_tick_prescaler.sv | 32 +++
 rtl/led_pattern_scheduler.sv | 144 ++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_scheduler_pkg.sv
// Shared constants and types for the LED pattern scheduler.
package led_pattern_scheduler_pkg;

  localparam int PAT_W  = 32;
  localparam int SLOT_W = 5;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 5'd31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // Index width for a set of n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Free-running clock divider: tick_o is high for one clock out of every DIV.
module led_pattern_scheduler_tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  // Count up and wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Divider counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Shares one LED among NUM_REQ requesters. Each accepted 32-slot pattern is
// played once, LSB first, one slot per prescaler tick; a heartbeat pattern
// loops whenever nothing is pending. Arbitration happens only at pattern
// boundaries (slot 31 tick), so no pattern is ever cut short.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | looping IDLE_PATTERN, no owner
//   ST_PLAY | playing the pattern latched from owner_q
module led_pattern_scheduler
  import led_pattern_scheduler_pkg::*;
#(
  parameter int                NUM_REQ      = 2,
  parameter int                TICK_DIV     = 2097152,
  parameter logic [PAT_W-1:0]  IDLE_PATTERN = 32'h0000_0055
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [PAT_W*NUM_REQ-1:0]   req_pattern_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic                       led_o
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  logic              tick;
  logic              boundary;

  logic [SLOT_W-1:0] slot_q,   slot_d;
  logic [PAT_W-1:0]  shreg_q,  shreg_d;
  state_e            state_q,  state_d;
  logic [IDX_W-1:0]  owner_q,  owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              busy_q,   busy_d;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [PAT_W-1:0]  grant_pat;
  logic [IDX_W-1:0]  rr_next;

  led_pattern_scheduler_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign boundary = tick && (slot_q == SLOT_LAST);

  // Round-robin search: first valid at or above rr_ptr, else first valid overall.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  // Select the winner's pattern and the pointer that follows it.
  always_comb begin
    grant_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_idx) begin
        grant_pat = req_pattern_i[PAT_W*i +: PAT_W];
      end
    end
    rr_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
  end

  // Accept and completion pulses, both tied to the boundary tick.
  always_comb begin
    req_ready_o = '0;
    done_o      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = boundary && grant_found && (grant_idx == IDX_W'(i));
      done_o[i]      = boundary && (state_q == ST_PLAY) && (owner_q == IDX_W'(i));
    end
  end

  // Next-state: shift within a pattern, reload from arbiter or heartbeat at the boundary.
  always_comb begin
    slot_d   = slot_q;
    shreg_d  = shreg_q;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    busy_d   = busy_q;
    if (tick) begin
      if (slot_q != SLOT_LAST) begin
        shreg_d = shreg_q >> 1;
        slot_d  = slot_q + SLOT_W'(1);
      end else if (grant_found) begin
        shreg_d  = grant_pat;
        slot_d   = '0;
        owner_d  = grant_idx;
        rr_ptr_d = rr_next;
        state_d  = ST_PLAY;
        busy_d   = 1'b1;
      end else begin
        shreg_d = IDLE_PATTERN;
        slot_d  = '0;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  // Scheduler state registers; reset parks at slot 31 so the first tick reloads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q   <= SLOT_LAST;
      shreg_q  <= '0;
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      shreg_q  <= shreg_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign led_o  = shreg_q[0];

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with TICK_DIV=4, NUM_REQ=2.
// Boundary (slot-31 tick) cycles fall at cyc = 3 + 128*k after reset release.
module tb_led_pattern_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_pattern;
  logic [1:0]  req_ready;
  logic [1:0]  done;
  logic        busy;
  logic        led;

  int cyc;
  int n_checks;
  int n_pass;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  ready;
    logic [1:0]  done;
    logic        busy;
    logic [31:0] shown;
  } vec_t;

  vec_t vecs[11];

  led_pattern_scheduler #(
    .NUM_REQ      (2),
    .TICK_DIV     (4),
    .IDLE_PATTERN (32'h0000_0055)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_pattern_i (req_pattern),
    .req_ready_o   (req_ready),
    .done_o        (done),
    .busy_o        (busy),
    .led_o         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic at_cycle(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != c) begin
      n_checks++;
      $display("FAIL at_cycle: got cyc %0d expected %0d", cyc, c);
    end
  endtask

  initial begin
    int b;
    logic [31:0] sh;
    logic        seen;

    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_pattern = '0;

    //              valid  p0            p1            ready  done   busy  shown
    vecs[0]  = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 32'h0000_0055};
    vecs[1]  = '{2'b01, 32'hF000_000F, 32'h0,        2'b01, 2'b00, 1'b1, 32'hF000_000F};
    vecs[2]  = '{2'b10, 32'h0,        32'h0000_FFFF, 2'b10, 2'b01, 1'b1, 32'h0000_FFFF};
    vecs[3]  = '{2'b11, 32'h8000_0001, 32'h3C3C_3C3C, 2'b01, 2'b10, 1'b1, 32'h8000_0001};
    vecs[4]  = '{2'b10, 32'h0,        32'h3C3C_3C3C, 2'b10, 2'b01, 1'b1, 32'h3C3C_3C3C};
    vecs[5]  = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b10, 1'b0, 32'h0000_0055};
    vecs[6]  = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 1'b0, 32'h0000_0055};
    vecs[7]  = '{2'b01, 32'h0000_0001, 32'h0,        2'b01, 2'b00, 1'b1, 32'h0000_0001};
    vecs[8]  = '{2'b11, 32'hFFFF_0000, 32'h0F0F_00F0, 2'b10, 2'b01, 1'b1, 32'h0F0F_00F0};
    vecs[9]  = '{2'b01, 32'hFFFF_0000, 32'h0,        2'b01, 2'b10, 1'b1, 32'hFFFF_0000};
    vecs[10] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b01, 1'b0, 32'h0000_0055};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {58'd0, led, busy, req_ready, done}, 64'd0);
    rst = 1'b0;
    at_cycle(2);
    check("pre-first-tick led", {63'd0, led}, 64'd0);

    // Table: one vector per pattern frame
    for (int k = 0; k < 11; k++) begin
      b = 3 + 128 * k;
      at_cycle(b - 1);
      req_valid   = vecs[k].valid;
      req_pattern = {vecs[k].p1, vecs[k].p0};
      at_cycle(b);
      check($sformatf("v%0d ready/done", k), {60'd0, req_ready, done},
            {60'd0, vecs[k].ready, vecs[k].done});
      at_cycle(b + 1);
      req_valid = '0;
      sh = vecs[k].shown;
      for (int s = 0; s < 32; s++) begin
        at_cycle(b + 2 + 4 * s);
        check($sformatf("v%0d slot%0d led/busy/ready/done", k, s),
              {58'd0, led, busy, req_ready, done}, {58'd0, sh[s], vecs[k].busy, 4'b0000});
      end
    end

    // No preemption: req 1 raised at slot 10 of req 0's play waits for the boundary
    b = 3 + 128 * 11;
    at_cycle(b - 1);
    req_valid   = 2'b01;
    req_pattern = {32'h0000_00AA, 32'hC000_0003};
    at_cycle(b);
    check("np grant0", {60'd0, req_ready, done}, {60'd0, 2'b01, 2'b00});
    at_cycle(b + 1);
    req_valid = 2'b00;
    at_cycle(b + 41);
    req_valid = 2'b10;
    seen = 1'b0;
    for (int c = b + 41; c < b + 128; c++) begin
      at_cycle(c);
      if (req_ready != 2'b00) seen = 1'b1;
    end
    check("np no early ready", {63'd0, seen}, 64'd0);
    b = 3 + 128 * 12;
    at_cycle(b);
    check("np boundary ready1+done0", {60'd0, req_ready, done}, {60'd0, 2'b10, 2'b01});

    // Each slot lasts exactly TICK_DIV cycles (pattern 0xAA, first four slots)
    sh = 32'h0000_00AA;
    for (int c = 0; c < 16; c++) begin
      at_cycle(b + 1 + c);
      if (c == 0) req_valid = 2'b00;
      check($sformatf("slot width c%0d led", c), {63'd0, led}, {63'd0, sh[c / 4]});
    end

    // Dropped request during idle frame gets no grant
    b = 3 + 128 * 13;
    at_cycle(b);
    check("drop done1", {60'd0, req_ready, done}, {60'd0, 2'b00, 2'b10});
    at_cycle(b + 2);
    check("drop idle led/busy", {62'd0, led, busy}, {62'd0, 2'b10});
    at_cycle(b + 14);
    req_valid = 2'b10;
    at_cycle(b + 80);
    req_valid = 2'b00;
    b = 3 + 128 * 14;
    at_cycle(b);
    check("drop no ready/done", {60'd0, req_ready, done}, 64'd0);
    at_cycle(b + 2);
    check("drop heartbeat s0", {62'd0, led, busy}, {62'd0, 2'b10});
    at_cycle(b + 6);
    check("drop heartbeat s1", {62'd0, led, busy}, {62'd0, 2'b00});

    // Reset at slot 15 of a play aborts it with no done pulse
    b = 3 + 128 * 15;
    at_cycle(b - 1);
    req_valid   = 2'b01;
    req_pattern = {32'h0, 32'hFFFF_FFFF};
    at_cycle(b);
    check("rst grant0", {60'd0, req_ready, done}, {60'd0, 2'b01, 2'b00});
    at_cycle(b + 1);
    req_valid = 2'b00;
    at_cycle(b + 58);
    check("rst playing s14", {62'd0, led, busy}, {62'd0, 2'b11});
    at_cycle(b + 62);
    rst = 1'b1;
    #1;
    check("rst immediate", {58'd0, led, busy, req_ready, done}, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    check("rst no done", {63'd0, seen}, 64'd0);
    rst = 1'b0;
    at_cycle(3);
    check("post-rst boundary", {59'd0, busy, req_ready, done}, 64'd0);
    at_cycle(5);
    check("post-rst idle s0", {62'd0, led, busy}, {62'd0, 2'b10});
    at_cycle(9);
    check("post-rst idle s1", {62'd0, led, busy}, {62'd0, 2'b00});
    at_cycle(13);
    check("post-rst idle s2", {62'd0, led, busy}, {62'd0, 2'b10});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
